// File: rtl/umi_arbiter.sv
// rtl/umi_arbiter.sv - round-robin / fixed-priority one-hot grant arbiter for the UMI packet mux
// Grants are held across back-pressure until the granted packet handshakes.
module umi_arbiter #(
    parameter int N          = 4,
    parameter bit ROUNDROBIN = 1'b1
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] umi_in_valid,
    output logic [N-1:0] umi_in_ready,
    input  logic         umi_out_ready,
    output logic [N-1:0] umi_grant,
    output logic         umi_out_valid
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  lock_q, lock_d;
    logic [N-1:0]  search_gnt;
    logic [N-1:0]  gnt;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] sel;
    logic          found;
    int            idx;

    // Rotating search starting at ptr_q, first asserted valid wins.
    always_comb begin
        search_gnt = '0;
        found      = 1'b0;
        idx        = 0;
        sel        = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = idx[PW-1:0];
            if (!found && umi_in_valid[sel]) begin
                search_gnt[sel] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    // A held grant ignores new requests; it vanishes if its requester drops valid.
    always_comb begin
        gnt = '0;
        if (nreset) begin
            gnt = (|lock_q) ? (lock_q & umi_in_valid) : search_gnt;
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    always_comb begin
        lock_d = (|gnt && !umi_out_ready) ? gnt : '0;
        ptr_d  = ptr_q;
        if (ROUNDROBIN && |gnt && umi_out_ready) begin
            ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q  <= '0;
            lock_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
        end
    end

    assign umi_grant     = gnt;
    assign umi_out_valid = |gnt;
    assign umi_in_ready  = nreset ? (~umi_in_valid | (gnt & {N{umi_out_ready}})) : '0;

`ifdef UMI_ARBITER_SVA
    a_onehot : assert property (@(posedge clk) disable iff (!nreset)
        $onehot0(umi_grant));
    a_subset : assert property (@(posedge clk) disable iff (!nreset)
        (umi_grant & ~umi_in_valid) == '0);
    a_held   : assert property (@(posedge clk) disable iff (!nreset)
        (|(lock_q & umi_in_valid)) |-> (umi_grant == lock_q));
`endif

endmodule

// File: tb/tb_umi_arbiter.sv
// tb/tb_umi_arbiter.sv - randomized and directed checks of umi_arbiter against a behavioural model
module tb_umi_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [N-1:0] valid = 4'b1111;
    logic         ready = 1'b0;

    logic [N-1:0] rr_in_ready, rr_grant, fp_in_ready, fp_grant;
    logic         rr_out_valid, fp_out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    umi_arbiter #(.N(N), .ROUNDROBIN(1'b1)) dut_rr (
        .clk(clk), .nreset(nreset), .umi_in_valid(valid), .umi_in_ready(rr_in_ready),
        .umi_out_ready(ready), .umi_grant(rr_grant), .umi_out_valid(rr_out_valid)
    );

    umi_arbiter #(.N(N), .ROUNDROBIN(1'b0)) dut_fp (
        .clk(clk), .nreset(nreset), .umi_in_valid(valid), .umi_in_ready(fp_in_ready),
        .umi_out_ready(ready), .umi_grant(fp_grant), .umi_out_valid(fp_out_valid)
    );

    always #5 clk = ~clk;

    // Model state: locked requester index (-1 = none) and priority pointer.
    int rr_lk = -1;
    int rr_ptr = 0;
    int fp_lk = -1;

    function automatic int pick(logic [N-1:0] v, int lk, int p);
        if (lk >= 0) return v[lk] ? lk : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rr_lk  <= -1;
            rr_ptr <= 0;
            fp_lk  <= -1;
        end else begin
            rr_lk <= (pick(valid, rr_lk, rr_ptr) >= 0 && !ready) ? pick(valid, rr_lk, rr_ptr) : -1;
            fp_lk <= (pick(valid, fp_lk, 0) >= 0 && !ready) ? pick(valid, fp_lk, 0) : -1;
            if (pick(valid, rr_lk, rr_ptr) >= 0 && ready)
                rr_ptr <= (pick(valid, rr_lk, rr_ptr) + 1) % N;
        end
    end

    logic [N-1:0] e_rr, e_fp, e_rr_rdy, e_fp_rdy;

    always @(negedge clk) begin
        e_rr     = nreset ? onehot(pick(valid, rr_lk, rr_ptr)) : '0;
        e_fp     = nreset ? onehot(pick(valid, fp_lk, 0)) : '0;
        e_rr_rdy = nreset ? (~valid | (e_rr & {N{ready}})) : '0;
        e_fp_rdy = nreset ? (~valid | (e_fp & {N{ready}})) : '0;
        chk("rr_grant", rr_grant, e_rr);
        chk("rr_in_ready", rr_in_ready, e_rr_rdy);
        chk("rr_out_valid", {3'b000, rr_out_valid}, {3'b000, |e_rr});
        chk("fp_grant", fp_grant, e_fp);
        chk("fp_in_ready", fp_in_ready, e_fp_rdy);
        chk("fp_out_valid", {3'b000, fp_out_valid}, {3'b000, |e_fp});
    end

    task automatic drive(input logic [N-1:0] v, input logic r);
        @(posedge clk);
        #1;
        valid = v;
        ready = r;
        #2;
    endtask

    initial begin
        #3;
        chk("lit_reset_grant", rr_grant, 4'b0000);
        chk("lit_reset_in_ready", rr_in_ready, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        ready  = 1'b1;
        #2;
        chk("lit_release_grant", rr_grant, 4'b0001);
        chk("lit_release_fp_grant", fp_grant, 4'b0001);

        for (int i = 1; i < 8; i++) begin
            drive(4'b1111, 1'b1);
            chk("lit_rr_rotate", rr_grant, onehot(i % N));
            chk("lit_fp_fixed", fp_grant, 4'b0001);
        end

        drive(4'b0110, 1'b0);
        chk("lit_bp_grant0", rr_grant, 4'b0010);
        chk("lit_bp_in_ready", rr_in_ready, 4'b1001);
        drive(4'b0110, 1'b0);
        chk("lit_bp_grant1", rr_grant, 4'b0010);
        drive(4'b0110, 1'b0);
        chk("lit_bp_grant2", rr_grant, 4'b0010);
        drive(4'b0111, 1'b0);
        chk("lit_bp_ignore_hi", rr_grant, 4'b0010);
        drive(4'b0110, 1'b1);
        chk("lit_bp_release", rr_grant, 4'b0010);
        chk("lit_bp_rdy_hs", rr_in_ready, 4'b1011);
        drive(4'b0110, 1'b1);
        chk("lit_bp_next", rr_grant, 4'b0100);

        for (int i = 0; i < 4; i++) begin
            drive(4'b1010, 1'b1);
            chk("lit_fp_starve", fp_grant, 4'b0010);
        end

        drive(4'b0100, 1'b0);
        chk("lit_drop_lockgrant", rr_grant, 4'b0100);
        drive(4'b1000, 1'b0);
        chk("lit_drop_zero", rr_grant, 4'b0000);
        drive(4'b1000, 1'b0);
        chk("lit_drop_resume", rr_grant, 4'b1000);

        drive(4'b0100, 1'b1);
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        chk("lit_rst_pre", rr_grant, 4'b0100);
        nreset = 1'b0;
        #1;
        chk("lit_rst_mid_grant", rr_grant, 4'b0000);
        chk("lit_rst_mid_in_ready", rr_in_ready, 4'b0000);
        chk("lit_rst_mid_out_valid", {3'b000, rr_out_valid}, 4'b0000);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        valid  = 4'b0101;
        ready  = 1'b0;
        #2;
        chk("lit_rst_after", rr_grant, 4'b0001);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) valid = 4'($urandom_range(0, 15));
            ready  = ($urandom_range(0, 2) != 0);
            nreset = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/umi_arbiter.md
Name: umi_arbiter

Overview:
- Round-robin (or fixed-priority) arbiter that sits directly upstream of the one-hot UMI packet mux.
- Takes N UMI request valids and produces a strictly one-hot (or zero) grant vector. The mux consumes that vector as its per-input valid/select, so its one-hot assumption is guaranteed by construction.
- Holds a grant stable across back-pressure until the selected transaction handshakes, so a packet is never switched mid-offer.

Parameters:
- N, 4, number of requesting inputs (N >= 2)
- ROUNDROBIN, 1, 1 = rotating priority; 0 = fixed priority (index 0 highest)

Ports:
- clk  input  1  clock; all state updates on rising edge
- nreset  input  1  asynchronous active-low reset
- umi_in_valid  input  N  request valids from the N upstream sources
- umi_in_ready  output  N  ready back to each source
- umi_out_ready  input  1  ready from downstream (mux output side)
- umi_grant  output  N  one-hot grant; drives the mux per-input valid/select
- umi_out_valid  output  1  OR of umi_grant

Behaviour:
- Clock and reset: one clock (clk). Reset nreset is asynchronous, active-low.
- State:
  - ptr[$clog2(N)-1:0]: index of the highest-priority input.
  - lock[N-1:0]: held grant; zero when unlocked.
- Reset (nreset=0, asynchronous):
  - ptr=0, lock=0.
  - umi_grant, umi_out_valid and umi_in_ready are forced to 0 while nreset=0.
- Unlocked (lock==0):
  - umi_grant is the first asserted umi_in_valid bit, searching ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N). This is combinational, zero-cycle latency.
  - If no valid is asserted, umi_grant=0.
- Locked (lock!=0):
  - umi_grant = lock & umi_in_valid. New requests are ignored, including higher-priority ones.
- Lock set:
  - Condition: umi_grant!=0 and umi_out_ready=0 at a clock edge.
  - Action: lock <= umi_grant.
- Handshake:
  - Condition: umi_out_valid & umi_out_ready at an edge.
  - Action: lock <= 0.
  - If ROUNDROBIN=1: ptr <= (granted index + 1) mod N, wrapping N-1 -> 0.
  - If ROUNDROBIN=0: ptr stays 0 permanently.
- Locked requester drops valid (protocol violation):
  - umi_grant becomes 0 immediately.
  - lock clears at the next edge; ptr unchanged.
  - Arbitration resumes the following cycle.
- Ready generation: umi_in_ready[i] = ~umi_in_valid[i] | (umi_grant[i] & umi_out_ready).
  - A valid but non-granted input always sees ready=0.
- Invariants:
  - $onehot0(umi_grant) every cycle.
  - umi_grant is a subset of umi_in_valid.
  - While lock!=0 and valid is held, umi_grant is constant.
- Simultaneous events:
  - Handshake plus new requests in the same cycle: the next grant uses the updated ptr.
  - Single requester with continuous ready: granted every cycle, throughput 1 packet/cycle.
- Optional SVA (ifdef'd) checks the invariants above.

Test Plan:
- Reset: nreset=0 with umi_in_valid=4'b1111 -> umi_grant=0, umi_in_ready=0. Release with ready=1 -> grant=4'b0001 the same cycle.
- Round-robin fairness: umi_in_valid=4'b1111, umi_out_ready=1 for 8 cycles -> grants 0001, 0010, 0100, 1000, 0001, ... (wrap verified).
- Back-pressure lock:
  - Valid=4'b0110, ptr=0, ready=0 for 3 cycles -> grant=4'b0010 held all 3 cycles.
  - Assert valid[0] mid-stall -> grant remains 0010.
  - Ready=1 -> handshake, next grant=4'b0100.
- Fixed priority (ROUNDROBIN=0): valid=4'b1010, ready=1 for 4 cycles -> grant=4'b0010 every cycle. Input 3 is starved, by design.
- Valid drop while locked: grant 0100 locked under stall, requester 2 deasserts valid -> grant=0 that cycle. Next cycle, with valid=4'b1000, grant=4'b1000.
- Reset mid-stall: lock=0100, ptr=2, assert nreset=0 -> outputs 0 immediately. After release with valid=4'b0101 -> grant=4'b0001.
